// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the CPU fetch and data ports.
// One access is in flight at a time; completion is signalled by a registered one-cycle ready pulse.
module mem_port_arbiter #(
   parameter int ALEN         = 32,
   parameter int XLEN         = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [ALEN-1:0] if_addr,
   output logic [31:0]     if_rdata,
   output logic            if_ready,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [ALEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [3:0]      d_be,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_ready,
   output logic            mem_req,
   output logic            mem_we,
   output logic [ALEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT        = 4'(MEM_LATENCY);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state_r;
   state_t     state_s;
   logic [3:0] cnt_r;
   logic [3:0] streak_r;
   logic       owner_r;
   logic       issue_d_s;
   logic       issue_f_s;

   // Arbitration: data wins unless a waiting fetch has been starved long enough.
   always_comb begin
      issue_d_s = 1'b0;
      issue_f_s = 1'b0;
      if (rst && state_r == IDLE) begin
         if (d_req && (!if_req || streak_r < STARVE_MAX)) begin
            issue_d_s = 1'b1;
         end else if (if_req) begin
            issue_f_s = 1'b1;
         end else begin
            issue_d_s = 1'b0;
         end
      end else begin
         issue_f_s = 1'b0;
      end
   end

   // Memory-side drive, active only in the issue cycle.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = {ALEN{1'b0}};
      mem_wdata = {XLEN{1'b0}};
      if (issue_d_s) begin
         mem_req   = 1'b1;
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (issue_f_s) begin
         mem_req   = 1'b1;
         mem_be    = 4'b1111;
         mem_addr  = if_addr;
      end else begin
         mem_req   = 1'b0;
      end
   end

   // Next-state logic; writes skip WAIT because nothing comes back.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (issue_d_s) begin
               state_s = d_we ? RESP : WAIT;
            end else if (issue_f_s) begin
               state_s = WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == LAT) begin
               state_s = RESP;
            end else begin
               state_s = WAIT;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, latency/streak counters, read-data capture and ready pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         streak_r <= 4'd0;
         owner_r  <= 1'b0;
         if_rdata <= 32'd0;
         d_rdata  <= {XLEN{1'b0}};
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
      end else begin
         state_r  <= state_s;
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (issue_d_s) begin
                  owner_r <= 1'b1;
                  cnt_r   <= 4'd1;
                  d_ready <= d_we;
                  if (!if_req) begin
                     streak_r <= 4'd0;
                  end else if (streak_r < STARVE_MAX) begin
                     streak_r <= streak_r + 4'd1;
                  end else begin
                     streak_r <= streak_r;
                  end
               end else if (issue_f_s) begin
                  owner_r  <= 1'b0;
                  cnt_r    <= 4'd1;
                  streak_r <= 4'd0;
               end else begin
                  cnt_r <= 4'd0;
               end
            end
            WAIT: begin
               if (cnt_r == LAT) begin
                  if (owner_r) begin
                     d_rdata <= mem_rdata;
                     d_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata[31:0];
                     if_ready <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            RESP:    cnt_r <= 4'd0;
            default: cnt_r <= 4'd0;
         endcase
      end
   end

   assign busy = (state_r != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and the CPU data port.
- Arbitrates between the two requesters, sequences one access at a time with a fixed read latency, and returns registered read data with a one-cycle ready pulse.
- Sits between the pipelined CPU's imem_*/dmem_* interfaces and the memory macro. The CPU stalls on a missing ready.

Parameters:
ALEN, 32, address width
XLEN, 32, data width
MEM_LATENCY, 2, cycles from issue to mem_rdata valid; legal range 1..8
STARVE_LIMIT, 4, max consecutive data grants while a fetch is waiting; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
if_req  in  1  fetch request; held until if_ready
if_addr  in  ALEN  fetch address
if_rdata  out  32  fetched instruction, registered
if_ready  out  1  one-cycle pulse: if_rdata valid, fetch complete
d_req  in  1  data request; held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ALEN  data address
d_wdata  in  XLEN  write data
d_be  in  4  byte enables
d_rdata  out  XLEN  load data, registered
d_ready  out  1  one-cycle pulse: data access complete
mem_req  out  1  issue strobe to memory
mem_we  out  1  write enable
mem_addr  out  ALEN  memory address
mem_wdata  out  XLEN  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  XLEN  read data, valid exactly MEM_LATENCY cycles after issue
busy  out  1  access outstanding (WAIT or RESP)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, latency counter=0, streak counter=0, owner=FETCH.
  - if_rdata=0, d_rdata=0, if_ready=0, d_ready=0.
  - mem_req forced 0 while rst=0. busy=0.
- States:
  - IDLE:
    - Arbitrate combinationally among requests present this cycle.
    - If a winner exists, drive mem_* from it, mem_req=1 for that cycle, and record the owner.
    - Next state: WAIT for a read, RESP for a write.
  - WAIT:
    - Counter counts from 1. mem_req=0.
    - At the edge ending cycle T+MEM_LATENCY (T = issue cycle), capture mem_rdata into the owner's rdata register. Next state: RESP.
  - RESP:
    - Owner's ready=1 for exactly one cycle. No issue in this cycle. Next state: IDLE.
- Latency:
  - Read issued in cycle T gives ready in cycle T+MEM_LATENCY+1.
  - Write issued in cycle T gives d_ready in cycle T+1.
  - Back-to-back issue spacing: MEM_LATENCY+2 cycles for reads, 2 cycles for writes.
- Arbitration in IDLE:
  - Data wins if d_req=1 and (if_req=0 or streak<STARVE_LIMIT). Otherwise a fetch wins if if_req=1.
  - Streak counter:
    - Increments on a data grant while if_req=1.
    - Clears on a fetch grant, or on a data grant while if_req=0.
    - Saturates at STARVE_LIMIT.
- Fetch mem_* fields:
  - mem_we=0, mem_be=4'b1111, mem_addr=if_addr, mem_wdata=0.
- Data mem_* fields:
  - d_we, d_be, d_addr and d_wdata pass through.
- Outside the issue cycle:
  - mem_we=0, mem_be=0; mem_addr and mem_wdata are don't-care.
- Handshake:
  - Requester holds req and fields stable from assertion through its ready cycle.
  - The cycle after ready, the requester either deasserts req or presents a new request.
  - Inputs are sampled only in the IDLE issue cycle; later changes do not affect an in-flight access.
- Writes:
  - d_rdata is unchanged.
  - A data read with d_be≠1111 still returns the full word; the CPU extracts bytes.
- Held data:
  - if_rdata and d_rdata hold their values until the next completion for the same owner.
- Reset mid-operation:
  - The outstanding access is abandoned: no ready pulse, and late mem_rdata is ignored.
  - The first cycle after rst returns high is IDLE.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - The loser stays pending and is considered in the next IDLE cycle.

Test Plan:
1. MEM_LATENCY=2; if_req=1, if_addr=0x100 at cycle 0; mem_rdata=0x00500093 in cycle 2 -> mem_req=1 only in cycle 0; if_ready=1 in cycle 3 only, with if_rdata=0x00500093; busy=1 in cycles 1-3.
2. MEM_LATENCY=2; if_req and d_req (read, d_addr=0x2000) both at cycle 0 -> data issued cycle 0, d_ready cycle 3; fetch issued cycle 4, if_ready cycle 7.
3. STARVE_LIMIT=2, MEM_LATENCY=2; d_req reads continuously with new requests and if_req held -> data grants in cycles 0 and 4, fetch grant in cycle 8, data grant in cycle 12; streak clears after the fetch.
4. d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF at cycle 0 -> in cycle 0, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_ready cycle 1; d_rdata unchanged.
5. Fetch issued cycle 0; rst=0 in cycle 1; mem_rdata=0xFFFFFFFF in cycle 2 -> no if_ready; if_rdata=0; busy=0 from cycle 2; a new fetch after reset release issues normally.
6. d_req only, with if_req=0 for 10 consecutive data reads, then if_req=1 -> streak stays 0 and the fetch is granted at the next IDLE after the current access.
